debounce_multi: RTL and testbench

//  Parametrised N-channel button conditioner for the game's input front-end.

---
 rtl/debounce_multi_if.sv | 22 ++
 rtl/debounce_multi.sv | 146 ++++++++++++++
 tb/tb_debounce_multi.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_multi_if.sv
// Button inputs and conditioned outputs of debounce_multi, grouped as one port.
// No flow control: outputs are a debounced level plus one-clk event pulses.
interface debounce_multi_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0] button;
   logic [N_CH-1:0] pressed;
   logic [N_CH-1:0] press;
   logic [N_CH-1:0] release_pulse;
   logic [N_CH-1:0] repeat_pulse;
   logic            tick;

   modport master (
      output button,
      input  pressed, press, release_pulse, repeat_pulse, tick
   );

   modport slave (
      input  button,
      output pressed, press, release_pulse, repeat_pulse, tick
   );
endinterface

// File: rtl/debounce_multi.sv
// N-channel button sync/debounce with press/release/auto-repeat pulses; latency 2 clk + THRESHOLD ticks.
// No backpressure: every event is a single-clk pulse that the consumer must take when it appears.
module debounce_multi #(
   parameter int N_CH          = 4,
   parameter int TICK_DIV      = 50000,
   parameter int THRESHOLD     = 3,
   parameter int ACTIVE_LOW    = 0,
   parameter int REPEAT_EN     = 1,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic             clk,
   input  logic             rst,
   debounce_multi_if.slave  bus
);
   localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW   = $clog2(THRESHOLD + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [PW-1:0]   P_LAST   = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0]   C_LAST   = CW'(THRESHOLD - 1);
   localparam logic [N_CH-1:0] INACTIVE = {N_CH{ACTIVE_LOW != 0}};

   logic [PW-1:0]   pcnt;
   logic            tick;
   logic [N_CH-1:0] sync1, sync2, s;
   logic [CW-1:0]   scnt [N_CH];
   logic [N_CH-1:0] pressed_q, press_q, release_q, rpt;
   logic [N_CH-1:0] flip, rise, fall;

   assign tick = (pcnt == P_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       pcnt <= '0;
      else if (tick) pcnt <= '0;
      else           pcnt <= pcnt + 1'b1;
   end

   // Sync flops reset to the released level so a held button reads as a fresh press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= INACTIVE;
         sync2 <= INACTIVE;
      end else begin
         sync1 <= bus.button;
         sync2 <= sync1;
      end
   end

   assign s = sync2 ^ INACTIVE;

   always_comb begin
      flip = '0;
      for (int i = 0; i < N_CH; i++)
         flip[i] = tick && (s[i] != pressed_q[i]) && (scnt[i] == C_LAST);
   end

   assign rise = flip & s;
   assign fall = flip & ~s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pressed_q <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < N_CH; i++) scnt[i] <= '0;
      end else begin
         pressed_q <= pressed_q ^ flip;
         press_q   <= rise;
         release_q <= fall;
         for (int i = 0; i < N_CH; i++) begin
            if (tick) begin
               if ((s[i] == pressed_q[i]) || (scnt[i] == C_LAST)) scnt[i] <= '0;
               else                                              scnt[i] <= scnt[i] + 1'b1;
            end
         end
      end
   end

   generate
      if (REPEAT_EN != 0) begin : g_rpt
         typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEATING} rstate_t;

         localparam logic [RW-1:0] D_LAST = RW'(REPEAT_DELAY - 1);
         localparam logic [RW-1:0] R_LAST = RW'(REPEAT_PERIOD - 1);

         rstate_t         st   [N_CH];
         logic [RW-1:0]   rcnt [N_CH];
         logic [N_CH-1:0] rpt_q;

         // Release is checked first so it suppresses a repeat due on the same tick.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rpt_q <= '0;
               for (int i = 0; i < N_CH; i++) begin
                  st[i]   <= S_IDLE;
                  rcnt[i] <= '0;
               end
            end else begin
               rpt_q <= '0;
               for (int i = 0; i < N_CH; i++) begin
                  if (fall[i]) begin
                     st[i]   <= S_IDLE;
                     rcnt[i] <= '0;
                  end else if (rise[i]) begin
                     st[i]   <= S_WAIT;
                     rcnt[i] <= '0;
                  end else if (tick) begin
                     case (st[i])
                        S_WAIT: begin
                           if (rcnt[i] == D_LAST) begin
                              rpt_q[i] <= 1'b1;
                              st[i]    <= S_REPEATING;
                              rcnt[i]  <= '0;
                           end else begin
                              rcnt[i]  <= rcnt[i] + 1'b1;
                           end
                        end
                        S_REPEATING: begin
                           if (rcnt[i] == R_LAST) begin
                              rpt_q[i] <= 1'b1;
                              rcnt[i]  <= '0;
                           end else begin
                              rcnt[i]  <= rcnt[i] + 1'b1;
                           end
                        end
                        default: rcnt[i] <= '0;
                     endcase
                  end
               end
            end
         end

         assign rpt = rpt_q;
      end else begin : g_no_rpt
         assign rpt = '0;
      end
   endgenerate

   assign bus.pressed       = pressed_q;
   assign bus.press         = press_q;
   assign bus.release_pulse = release_q;
   assign bus.repeat_pulse  = rpt;
   assign bus.tick          = tick;
endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: a tick/sample-history model checked every cycle, plus directed timing literals.
module tb_debounce_multi;
   localparam int TD0 = 4, TD1 = 1, THR = 3, RD = 5, RP = 2;
   localparam int MASK = (1 << THR) - 1;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rst1 = 1'b1;
   always #5 clk = ~clk;

   debounce_multi_if #(.N_CH(4)) bus0 ();
   debounce_multi_if #(.N_CH(4)) bus1 ();

   debounce_multi #(.N_CH(4), .TICK_DIV(TD0), .THRESHOLD(THR), .ACTIVE_LOW(0), .REPEAT_EN(1),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));

   debounce_multi #(.N_CH(4), .TICK_DIV(TD1), .THRESHOLD(THR), .ACTIVE_LOW(1), .REPEAT_EN(1),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
      dut1 (.clk(clk), .rst(rst1), .bus(bus1));

   logic [3:0] a_pr [2], a_ps [2], a_rl [2], a_rp [2];
   logic       a_tk [2];
   assign a_pr[0] = bus0.pressed;  assign a_pr[1] = bus1.pressed;
   assign a_ps[0] = bus0.press;    assign a_ps[1] = bus1.press;
   assign a_rl[0] = bus0.release_pulse; assign a_rl[1] = bus1.release_pulse;
   assign a_rp[0] = bus0.repeat_pulse;  assign a_rp[1] = bus1.repeat_pulse;
   assign a_tk[0] = bus0.tick;     assign a_tk[1] = bus1.tick;

   int vectors = 0, miscompares = 0, cyc = 0;
   int rep_cnt [4];
   int rel_at  [4];

   // Model state: edges since reset, ticks since reset, 2-deep input delay,
   // per-channel disagreement history since the last level change, tick index of the last press.
   int         td  [2] = '{TD0, TD1};
   logic [3:0] alm [2] = '{4'h0, 4'hF};
   int         e_m [2], tickn [2];
   logic [3:0] h0 [2], h1 [2], lvl [2], x_ps [2], x_rl [2], x_rp [2];
   logic       x_tk [2];
   int         dis_bits [2][4];
   int         pt [2][4];

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
      end
   endtask

   task automatic mreset(input int k);
      e_m[k] = 0; tickn[k] = 0;
      h0[k] = '0; h1[k] = '0; lvl[k] = '0;
      x_ps[k] = '0; x_rl[k] = '0; x_rp[k] = '0;
      x_tk[k] = (td[k] == 1);
      for (int c = 0; c < 4; c++) begin
         dis_bits[k][c] = 0;
         pt[k][c] = 0;
      end
   endtask

   task automatic mstep(input int k, input logic [3:0] btn);
      logic [3:0] s_now;
      int d;
      e_m[k]++;
      s_now = h1[k];
      h1[k] = h0[k];
      h0[k] = btn ^ alm[k];
      x_ps[k] = '0; x_rl[k] = '0; x_rp[k] = '0;
      if ((e_m[k] % td[k]) == 0) begin
         tickn[k]++;
         for (int c = 0; c < 4; c++) begin
            dis_bits[k][c] = ((dis_bits[k][c] << 1) | int'(s_now[c] != lvl[k][c])) & MASK;
            if (dis_bits[k][c] == MASK) begin
               dis_bits[k][c] = 0;
               lvl[k][c] = s_now[c];
               if (s_now[c]) begin
                  x_ps[k][c] = 1'b1;
                  pt[k][c] = tickn[k];
               end else begin
                  x_rl[k][c] = 1'b1;
               end
            end else if (lvl[k][c]) begin
               d = tickn[k] - pt[k][c];
               if (d >= RD && ((d - RD) % RP) == 0) x_rp[k][c] = 1'b1;
            end
         end
      end
      x_tk[k] = ((e_m[k] + 1) % td[k]) == 0;
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst)  mreset(0); else mstep(0, bus0.button);
      if (rst1) mreset(1); else mstep(1, bus1.button);
   end

   always @(negedge clk) begin : cmp
      logic rk;
      for (int k = 0; k < 2; k++) begin
         rk = (k == 0) ? rst : rst1;
         chk("pressed", k, 32'(a_pr[k]), rk ? 32'h0 : 32'(lvl[k]));
         chk("press",   k, 32'(a_ps[k]), rk ? 32'h0 : 32'(x_ps[k]));
         chk("release", k, 32'(a_rl[k]), rk ? 32'h0 : 32'(x_rl[k]));
         chk("repeat",  k, 32'(a_rp[k]), rk ? 32'h0 : 32'(x_rp[k]));
         chk("tick",    k, 32'(a_tk[k]), rk ? 32'(td[k] == 1) : 32'(x_tk[k]));
      end
      for (int c = 0; c < 4; c++) begin
         if (a_rp[0][c]) rep_cnt[c] = rep_cnt[c] + 1;
         if (a_rl[0][c]) rel_at[c] = cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [3:0] sig(input int k, input int sel);
      case (sel)
         0:       return a_ps[k];
         1:       return a_rl[k];
         default: return a_rp[k];
      endcase
   endfunction

   // Returns the edge count at which the pulse was seen on channel ch, or -1 on timeout.
   task automatic wait_pulse(input int k, input int sel, input int ch, input int limit,
                             output int at, output logic [3:0] v);
      at = -1;
      v  = '0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (sig(k, sel)[ch]) begin
            at = cyc;
            v  = sig(k, sel);
            break;
         end
      end
   endtask

   initial begin
      int R, B, P, P3, X, Z, at, base;
      logic [3:0] v;
      bus0.button = 4'hF;
      bus1.button = 4'hF;

      // Reset with all buttons held, then release: fresh press after debounce.
      repeat (4) step();
      @(negedge clk);
      chk("lit_rst_pressed", 0, 32'(a_pr[0]), 32'h0);
      chk("lit_rst_press",   0, 32'(a_ps[0]), 32'h0);
      step();
      rst = 1'b0; rst1 = 1'b0; R = cyc;
      wait_pulse(0, 0, 0, 20, at, v);
      chk("lit_t1_press_time", 0, at, R + 12);
      chk("lit_t1_press_vec",  0, 32'(v), 32'hF);
      @(negedge clk);
      chk("lit_t1_pressed",  0, 32'(a_pr[0]), 32'hF);
      chk("lit_t1_one_clk",  0, 32'(a_ps[0]), 32'h0);
      step();
      bus0.button = 4'h0;
      wait_pulse(0, 1, 0, 40, at, v);
      chk("lit_t1_release_vec", 0, 32'(v), 32'hF);

      // Bounce on ch0, tick-aligned start, then steady high.
      step();
      while (((cyc - R) % 4) != 0) step();
      B = cyc;
      for (int j = 0; j < 14; j++) begin
         bus0.button[0] = ~j[0];
         repeat (3) step();
      end
      bus0.button[0] = 1'b1;
      wait_pulse(0, 0, 0, 30, at, v);
      chk("lit_t2_press_time", 0, at, B + 56);

      // Two-tick glitches on ch1, high while idle and low while held.
      step();
      while (((cyc - R) % 4) != 0) step();
      bus0.button[1] = 1'b1;
      repeat (8) step();
      bus0.button[1] = 1'b0;
      wait_pulse(0, 0, 1, 30, at, v);
      chk("lit_t3_glitch_high", 0, at, -1);
      step();
      bus0.button[1] = 1'b1;
      wait_pulse(0, 0, 1, 40, at, v);
      chk("lit_t3_real_press", 0, 32'(at != -1), 32'h1);
      step();
      while (((cyc - R) % 4) != 0) step();
      bus0.button[1] = 1'b0;
      repeat (8) step();
      bus0.button[1] = 1'b1;
      wait_pulse(0, 1, 1, 30, at, v);
      chk("lit_t3_glitch_low", 0, at, -1);
      chk("lit_t3_still_held", 0, 32'(a_pr[0][1]), 32'h1);

      // Auto-repeat on ch2.
      step();
      bus0.button[2] = 1'b1;
      wait_pulse(0, 0, 2, 40, P, v);
      for (int i = 0; i < 4; i++) begin
         wait_pulse(0, 2, 2, 24, at, v);
         chk("lit_t4_repeat_time", 0, at, P + 20 + 8 * i);
      end
      step();
      bus0.button[2] = 1'b0;
      wait_pulse(0, 1, 2, 40, at, v);
      chk("lit_t4_release_seen", 0, 32'(at != -1), 32'h1);
      wait_pulse(0, 2, 2, 40, at, v);
      chk("lit_t4_repeat_stops", 0, at, -1);

      // Release at tick 4 and at tick 5 after press on ch3: no repeat either way.
      for (int r = 0; r < 2; r++) begin
         step();
         bus0.button[3] = 1'b1;
         wait_pulse(0, 0, 3, 40, P3, v);
         base = rep_cnt[3];
         repeat (4 + 4 * r) step();
         bus0.button[3] = 1'b0;
         repeat (40) step();
         chk("lit_t5_release_time", 0, rel_at[3], P3 + 16 + 4 * r);
         chk("lit_t5_no_repeat",    0, rep_cnt[3] - base, 0);
      end

      // Active-low, tick every clk; reset mid-hold.
      step();
      bus1.button = 4'b1110;
      X = cyc;
      wait_pulse(1, 0, 0, 20, at, v);
      chk("lit_t6_press_time", 1, at, X + 5);
      repeat (12) step();
      rst1 = 1'b1;
      @(negedge clk);
      chk("lit_t6_rst_clears", 1, 32'(a_pr[1]), 32'h0);
      step();
      step();
      rst1 = 1'b0;
      Z = cyc;
      wait_pulse(1, 0, 0, 20, at, v);
      chk("lit_t6_fresh_press", 1, at, Z + 5);

      repeat (5) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
